// File: rtl/delay_timer_arbiter_if.sv
// Request/grant bundle between per-channel control FSMs and the shared delay timer.
// The master modport is the requester side; the slave modport is the arbiter side.
interface delay_timer_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] done;
   logic             busy;
   logic [1:0]       s_out;

   modport master (output req, input grant, input done, input busy, input s_out);
   modport slave  (input req, output grant, output done, output busy, output s_out);
endinterface

// File: rtl/delay_timer_arbiter.sv
// One DELAY-cycle timer shared by N_REQ requesters. Grant follows req by 1 edge and done by DELAY more; no queueing, losers hold req.
// Arbitration is round-robin by default; defining ARB_FIXED_PRIO_EN makes the lowest req index win.
module delay_timer_arbiter #(
   parameter int N_REQ = 4,
   parameter int DELAY = 2**20,
   parameter int CNT_W = 21
) (
   input  logic                 clk,
   input  logic                 rst,
   delay_timer_arbiter_if.slave bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      DONE    = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             win_vld;
   logic [IDX_W-1:0] win_idx;
   logic             abandon;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_vld && bus.req[IDX_W'(i)]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] last_q, last_d;
   int               cand;

   // Search starts just after the previous owner so every requester gets a turn.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = (int'(last_q) + i) % N_REQ;
         if (!win_vld && bus.req[IDX_W'(cand)]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(cand);
         end
      end
   end
`endif

   // The owner is whichever bit grant holds, so no separate owner index is needed.
   assign abandon = ~|(bus.req & grant_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      done_d  = '0;
`ifndef ARB_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (win_vld) begin
               state_d          = RUN;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
               last_d           = win_idx;
`endif
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (abandon) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(DELAY - 1)) begin
               state_d = DONE;
               done_d  = grant_q;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
         last_q  <= IDX_W'(N_REQ - 1);
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         done_q  <= done_d;
`ifndef ARB_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   assign bus.grant = grant_q;
   assign bus.done  = done_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.s_out = state_q;

endmodule
